sram_mem_responder: RTL and testbench

- Responder side of the MEM-stage data-memory interface.
- Accepts one word read/write request per instruction from the pipeline: read/write enables, byte address (ALU result), store value.
- Services each request on a 16-bit-wide asynchronous SRAM as two half-word accesses.
- Holds `ready` low to freeze the pipeline until the word transfer completes. Replaces the single-cycle on-chip data memory.

---
 rtl/sram_mem_responder_pkg.sv | 24 ++
 rtl/sram_mem_responder.sv | 135 +++++++++++++
 tb/tb_sram_mem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_responder_pkg.sv
// rtl/sram_mem_responder_pkg.sv - shared widths, SRAM timing and FSM encoding for the data-memory responder
package sram_mem_responder_pkg;

  localparam int DEF_WORD_LEN      = 32;
  localparam int DEF_SRAM_ADDR_LEN = 18;
  localparam int DEF_SRAM_DATA_LEN = 16;
  localparam int DEF_DATA_BASE     = 1024;
  localparam int DEF_SRAM_WAIT     = 2;

  localparam int SRAM_STATE_LEN = 2;

  typedef enum logic [SRAM_STATE_LEN-1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } sram_state_e;

  // True while a half-word access is on the SRAM pins.
  function automatic logic is_phase(input sram_state_e s);
    return (s == S_LO) || (s == S_HI);
  endfunction

endpackage

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - MEM-stage word load/store serviced as two half-word accesses on a 16-bit async SRAM
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int WORD_LEN      = DEF_WORD_LEN,
  parameter int SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
  parameter int SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
  parameter int DATA_BASE     = DEF_DATA_BASE,
  parameter int SRAM_WAIT     = DEF_SRAM_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [WORD_LEN-1:0]      ALU_res,
  input  logic [WORD_LEN-1:0]      ST_value,
  output logic [WORD_LEN-1:0]      dataMem_out,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_LEN-1:0] SRAM_DQ_O,
  input  logic [SRAM_DATA_LEN-1:0] SRAM_DQ_I,
  output logic                     SRAM_DQ_OE,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N
);

  localparam int CNT_W = $clog2(SRAM_WAIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_WAIT - 1);

  sram_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     wr_q, wr_d;
  logic [WORD_LEN-1:0]      data_q, data_d;
  logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SRAM_DATA_LEN-1:0] dq_o_q, dq_o_d;
  logic                     dq_oe_q, dq_oe_d;
  logic                     we_n_q, we_n_d;
  logic                     oe_n_q, oe_n_d;

  logic                     req;
  logic                     last;
  logic                     in_phase;
  logic [WORD_LEN-1:0]      offset;
  logic [SRAM_ADDR_LEN-2:0] idx;
  logic                     unused_addr_bits;

  // Out-of-range addresses simply wrap inside the SRAM.
  assign offset           = ALU_res - WORD_LEN'(DATA_BASE);
  assign idx              = offset[SRAM_ADDR_LEN:2];
  assign unused_addr_bits = ^{offset[WORD_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

  assign req   = MEM_R_EN | MEM_W_EN;
  assign last  = (cnt_q == '0);
  assign ready = ~req | (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = MEM_W_EN;
          addr_d  = {idx, 1'b0};
          cnt_d   = CNT_LOAD;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (last) begin
          addr_d  = {idx, 1'b1};
          cnt_d   = CNT_LOAD;
          state_d = S_HI;
          if (!wr_q) data_d[SRAM_DATA_LEN-1:0] = SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HI: begin
        if (last) begin
          state_d = S_DONE;
          if (!wr_q) data_d[WORD_LEN-1:SRAM_DATA_LEN] = SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin controls are registered, so derive them from the state being entered.
    in_phase = is_phase(state_d);
    we_n_d   = ~(in_phase && wr_d && (cnt_d != '0));
    oe_n_d   = ~(in_phase && !wr_d);
    dq_oe_d  = in_phase && wr_d;
    dq_o_d   = dq_o_q;
    if (in_phase && wr_d) begin
      dq_o_d = (state_d == S_HI) ? ST_value[WORD_LEN-1:SRAM_DATA_LEN]
                                 : ST_value[SRAM_DATA_LEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign dataMem_out = data_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_O   = dq_o_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb/tb_sram_mem_responder.sv - directed vector bench for sram_mem_responder with a small async SRAM model
module tb_sram_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_value;
  logic [31:0] data_mem_out;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  logic [15:0] sram [0:63];

  int total = 0;
  int bad   = 0;
  int row   = 0;

  sram_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (mem_r_en),
    .MEM_W_EN   (mem_w_en),
    .ALU_res    (alu_res),
    .ST_value   (st_value),
    .dataMem_out(data_mem_out),
    .ready      (ready),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ_O  (sram_dq_o),
    .SRAM_DQ_I  (sram_dq_i),
    .SRAM_DQ_OE (sram_dq_oe),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram[sram_addr[5:0]];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram[sram_addr[5:0]] <= sram_dq_o;
  end

  typedef struct {
    logic        rst_n;
    logic        r_en;
    logic        w_en;
    logic [31:0] alu;
    logic [31:0] st;
    logic        ready;
    logic [17:0] addr;
    logic        we_n;
    logic        oe_n;
    logic        dq_oe;
    logic [15:0] dq_o;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] s, input logic rdy, input logic [17:0] ad,
                     input logic we, input logic oe, input logic doe, input logic [15:0] dqo,
                     input logic [31:0] dout);
    vec_t v;
    v.rst_n = rs; v.r_en = r; v.w_en = w; v.alu = a; v.st = s;
    v.ready = rdy; v.addr = ad; v.we_n = we; v.oe_n = oe; v.dq_oe = doe;
    v.dq_o = dqo; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] s);
    rst = rs; mem_r_en = r; mem_w_en = w; alu_res = a; st_value = s;
  endtask

  localparam logic [31:0] A  = 32'd1028;
  localparam logic [31:0] B  = 32'd1032;
  localparam logic [31:0] SD = 32'hDEADBEEF;
  localparam logic [31:0] SC = 32'hCAFEF00D;

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 16'h0000;
    sram[2] = 16'h5678;
    sram[3] = 16'h1234;

    //   rst r  w  alu  st    rdy addr we oe doe dq_o      dout
    add(0, 0, 1, A, SD,   0, 0, 1, 1, 0, 16'h0000, 32'h0);
    add(1, 1, 0, A, 0,    0, 0, 1, 1, 0, 16'h0000, 32'h0);
    add(1, 1, 0, A, 0,    0, 2, 1, 0, 0, 16'h0000, 32'h0);
    add(1, 1, 0, A, 0,    0, 2, 1, 0, 0, 16'h0000, 32'h0);
    add(1, 1, 0, A, 0,    0, 3, 1, 0, 0, 16'h0000, 32'h00005678);
    add(1, 1, 0, A, 0,    0, 3, 1, 0, 0, 16'h0000, 32'h00005678);
    add(1, 1, 0, A, 0,    1, 3, 1, 1, 0, 16'h0000, 32'h12345678);
    add(1, 0, 1, A, SD,   0, 3, 1, 1, 0, 16'h0000, 32'h12345678);
    add(1, 0, 1, A, SD,   0, 2, 0, 1, 1, 16'hBEEF, 32'h12345678);
    add(1, 0, 1, A, SD,   0, 2, 1, 1, 1, 16'hBEEF, 32'h12345678);
    add(1, 0, 1, A, SD,   0, 3, 0, 1, 1, 16'hDEAD, 32'h12345678);
    add(1, 0, 1, A, SD,   0, 3, 1, 1, 1, 16'hDEAD, 32'h12345678);
    add(1, 0, 1, A, SD,   1, 3, 1, 1, 0, 16'hDEAD, 32'h12345678);
    add(1, 1, 0, A, 0,    0, 3, 1, 1, 0, 16'hDEAD, 32'h12345678);
    add(1, 1, 0, A, 0,    0, 2, 1, 0, 0, 16'hDEAD, 32'h12345678);
    add(1, 1, 0, A, 0,    0, 2, 1, 0, 0, 16'hDEAD, 32'h12345678);
    add(1, 1, 0, A, 0,    0, 3, 1, 0, 0, 16'hDEAD, 32'h1234BEEF);
    add(1, 1, 0, A, 0,    0, 3, 1, 0, 0, 16'hDEAD, 32'h1234BEEF);
    add(1, 1, 0, A, 0,    1, 3, 1, 1, 0, 16'hDEAD, 32'hDEADBEEF);
    add(1, 0, 0, 0, 0,    1, 3, 1, 1, 0, 16'hDEAD, 32'hDEADBEEF);
    add(1, 0, 0, 0, 0,    1, 3, 1, 1, 0, 16'hDEAD, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   0, 3, 1, 1, 0, 16'hDEAD, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   0, 4, 0, 1, 1, 16'hF00D, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   0, 4, 1, 1, 1, 16'hF00D, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   0, 5, 0, 1, 1, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   0, 5, 1, 1, 1, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 1, B, SC,   1, 5, 1, 1, 0, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 0, B, 0,    0, 5, 1, 1, 0, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 0, B, 0,    0, 4, 1, 0, 0, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 0, B, 0,    0, 4, 1, 0, 0, 16'hCAFE, 32'hDEADBEEF);
    add(1, 1, 0, B, 0,    0, 5, 1, 0, 0, 16'hCAFE, 32'hDEADF00D);
    add(1, 1, 0, B, 0,    0, 5, 1, 0, 0, 16'hCAFE, 32'hDEADF00D);
    add(1, 1, 0, B, 0,    1, 5, 1, 1, 0, 16'hCAFE, 32'hCAFEF00D);
    add(1, 0, 0, 0, 0,    1, 5, 1, 1, 0, 16'hCAFE, 32'hCAFEF00D);

    drive(0, 0, 1, A, SD);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      row = i;
      drive(vecs[i].rst_n, vecs[i].r_en, vecs[i].w_en, vecs[i].alu, vecs[i].st);
      #1;
      chk("ready",  {31'd0, ready},      {31'd0, vecs[i].ready});
      chk("addr",   {14'd0, sram_addr},  {14'd0, vecs[i].addr});
      chk("we_n",   {31'd0, sram_we_n},  {31'd0, vecs[i].we_n});
      chk("oe_n",   {31'd0, sram_oe_n},  {31'd0, vecs[i].oe_n});
      chk("dq_oe",  {31'd0, sram_dq_oe}, {31'd0, vecs[i].dq_oe});
      chk("dq_o",   {16'd0, sram_dq_o},  {16'd0, vecs[i].dq_o});
      chk("dout",   data_mem_out,        vecs[i].dout);
    end
    chk("mem_hw4", {16'd0, sram[4]}, 32'h0000F00D);
    chk("mem_hw5", {16'd0, sram[5]}, 32'h0000CAFE);

    // Reset lands in the last LO cycle of a store, then the request restarts.
    row = 1000;
    @(negedge clk); drive(1, 0, 1, A, 32'h11112222); #1;
    chk("rs_c0_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); #1;
    chk("rs_c1_we_n", {31'd0, sram_we_n}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rs_c2_we_n", {31'd0, sram_we_n}, 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rs_c3_we_n",  {31'd0, sram_we_n},  32'd1);
    chk("rs_c3_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rs_c3_oe_n",  {31'd0, sram_oe_n},  32'd1);
    chk("rs_c3_addr",  {14'd0, sram_addr},  32'd0);
    chk("rs_c3_ready", {31'd0, ready},      32'd0);
    chk("rs_c3_dout",  data_mem_out,        32'd0);
    @(negedge clk); #1;
    chk("rs_c4_addr",  {14'd0, sram_addr},  32'd2);
    chk("rs_c4_we_n",  {31'd0, sram_we_n},  32'd0);
    chk("rs_c4_dq_oe", {31'd0, sram_dq_oe}, 32'd1);
    chk("rs_c4_dq_o",  {16'd0, sram_dq_o},  32'h00002222);
    begin
      int n;
      n = 0;
      while (!ready && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk("rs_restart_latency", n, 32'd4);
    end
    @(negedge clk); drive(1, 0, 0, 0, 0); #1;
    chk("rs_mem_hw2",  {16'd0, sram[2]}, 32'h00002222);
    chk("rs_mem_hw3",  {16'd0, sram[3]}, 32'h00001111);
    chk("rs_idle_rdy", {31'd0, ready},   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
